// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FIFO default depth and drain-state encoding.
package uart_pkg;

  localparam int UART_TXF_DEPTH = 16;

  typedef enum logic [1:0] {
    TXF_IDLE  = 2'd0,
    TXF_ISSUE = 2'd1,
    TXF_GUARD = 2'd2
  } txf_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// CPU write path and buart handshake bundle for the transmit FIFO.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_TXF_DEPTH
);
  localparam int AW = $clog2(DEPTH);

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          flush;
  logic          clr_ovf;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          uart_wr;
  logic [7:0]    uart_tx_data;
  logic          uart_busy;

  modport slave (
    input  wr_en, wr_data, flush, clr_ovf, uart_busy,
    output full, empty, level, overflow, uart_wr, uart_tx_data
  );

  modport master (
    output wr_en, wr_data, flush, clr_ovf, uart_busy,
    input  full, empty, level, overflow, uart_wr, uart_tx_data
  );
endinterface

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered level/full/empty and registered read port.
module fifo_sync #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic          full_q, empty_q;
  logic [W-1:0]  rd_data_q;
  logic          push_ok, pop_ok;

  // Full/empty come from the registered flags only, so a same-cycle pop never rescues a push.
  assign push_ok = push & ~full_q;
  assign pop_ok  = pop & ~empty_q;

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush && !reset) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      rd_data_q <= '0;
    end else if (flush) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        rd_data_q <= mem[rd_ptr_q];
      end
      level_q <= level_d;
      full_q  <= (level_d == FULL_LVL);
      empty_q <= (level_d == '0);
    end
  end

  assign pop_data = rd_data_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer in front of buart: queues CPU bytes and drains them one strobe
// at a time, with a guard cycle so buart's registered busy is seen before the next issue.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_TXF_DEPTH
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_fifo_if.slave  bus
);
  txf_state_e state_q;
  logic       uart_wr_q;
  logic       overflow_q;
  logic       pop;
  logic       drop;

  fifo_sync #(
    .DEPTH (DEPTH),
    .W     (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.flush),
    .push      (bus.wr_en),
    .push_data (bus.wr_data),
    .pop       (pop),
    .pop_data  (bus.uart_tx_data),
    .full      (bus.full),
    .empty     (bus.empty),
    .level     (bus.level)
  );

  assign pop  = (state_q == TXF_IDLE) && !bus.empty && !bus.uart_busy && !bus.flush;
  assign drop = bus.wr_en && bus.full && !bus.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= TXF_IDLE;
      uart_wr_q <= 1'b0;
    end else if (bus.flush) begin
      state_q   <= TXF_IDLE;
      uart_wr_q <= 1'b0;
    end else begin
      case (state_q)
        TXF_IDLE: begin
          if (pop) begin
            uart_wr_q <= 1'b1;
            state_q   <= TXF_ISSUE;
          end
        end
        TXF_ISSUE: begin
          uart_wr_q <= 1'b0;
          state_q   <= TXF_GUARD;
        end
        TXF_GUARD: begin
          state_q <= TXF_IDLE;
        end
        default: begin
          uart_wr_q <= 1'b0;
          state_q   <= TXF_IDLE;
        end
      endcase
    end
  end

  assign bus.uart_wr  = uart_wr_q;
  assign bus.overflow = overflow_q;
endmodule
